mem_stage_hs: RTL
=================

// Module: mem_stage_hs
// PURPOSE
//  Pipelined MIPS memory-access stage with a req/ack RAM handshake, sits between EX/MEM and MEM/WB.
//  Generates byte enables and lane-replicated store data, and aligns and sign/zero-extends load data.
//  Raises stallreq_o until the RAM acknowledges, and aborts hung accesses with a timeout.
//  Non-memory instructions pass to WB with 1-cycle latency.
// PARAMETERS
//  ADDR_W      32   address width (ram_addr_o, addr_i, pc)
//  REG_AW      5    register-file address width
//  TIMEOUT_CYC 255  max BUSY cycles without ram_ack_i before abort (>=1)
// PORTS
//  clk           in   1        clock, rising edge
//  rst           in   1        reset, synchronous, active-high
//  valid_i       in   1        instruction present; inputs held stable while stallreq_o=1
//  op_i          in   4        0000 none,0001 LB,0010 LBU,0011 LH,0100 LHU,0101 LW,1001 SB,1010 SH,1011 SW
//  addr_i        in   ADDR_W   byte address
//  store_data_i  in   32       store source (rt)
//  wd_i/wreg_i   in   REG_AW/1 destination reg / write enable
//  wdata_i       in   32       ALU result (used for non-loads)
//  pc_i          in   ADDR_W   instruction PC
//  wb_valid_o    out  1        WB outputs valid this cycle
//  wd_o/wreg_o   out  REG_AW/1 destination / write enable to WB
//  wdata_o       out  32       result to WB
//  pc_o          out  ADDR_W   PC of retiring instruction
//  ram_req_o     out  1        RAM request, held until ack
//  ram_we_o      out  4        byte write enables (0 = read)
//  ram_addr_o    out  ADDR_W   word address {addr[ADDR_W-1:2],2'b00}
//  ram_wdata_o   out  32       lane-replicated store data
//  ram_ack_i     in   1        RAM completion; ram_rdata_i valid same cycle
//  ram_rdata_i   in   32       read word
//  stallreq_o    out  1        freeze upstream stages
//  bus_err_o     out  1        1-cycle pulse on timeout abort
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, timeout counter 0; rst in BUSY aborts, ram_req_o=0 next cycle.
//  - FSM IDLE->BUSY: valid_i & op_i[3|0..2] is mem op; latch op/addr/data; stallreq_o=1 combinationally.
//  - BUSY: ram_req_o=1, addr/we/wdata stable; stallreq_o=!ram_ack_i; counter increments.
//  - BUSY & ram_ack_i: next edge wb_valid_o=1 with load result or wdata_i; FSM->IDLE; req drops.
//  - BUSY & counter==TIMEOUT_CYC-1 & !ack: next edge wb_valid_o=1, wreg_o=0, bus_err_o=1, FSM->IDLE.
//    stallreq_o=0 in that last cycle. Ack and timeout in the same cycle: ack wins.
//  - Non-mem valid_i in IDLE: wb_* registered next edge, no stall; valid_i=0 -> wb_valid_o=0, wreg_o=0.
//  - Little-endian lanes, b=addr[1:0]:
//    SB: we=0001<<b, wdata={4{sd[7:0]}}; SH: we=addr[1]?1100:0011, wdata={2{sd[15:0]}}; SW: we=1111.
//  - Loads select byte b / half addr[1] from ram_rdata_i; LB/LH sign-extend, LBU/LHU zero-extend to 32.
//  - Stores retire with wreg_o=wreg_i (decoder drives 0); latency = request-to-ack cycles + 1.
//  - Back-to-back mem ops: IDLE always spends one cycle before request; min 2 cycles per mem op.
// CONFIGURATION
//  MEM_ALIGN_CHECK_EN defined:
//    - Misaligned access (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0) issues no RAM request.
//    - Next edge: wb_valid_o=1, wreg_o=0, align_err_o=1 (extra 1-bit output) for 1 cycle; no stall.
//  Undefined:
//    - No check and no align_err_o port; halfwords ignore addr[0], words ignore addr[1:0].
// TESTING
//  - ALU op, op_i=0, wdata_i=0x1234, wd_i=3, wreg_i=1 -> next cycle wb_valid_o=1, wdata_o=0x1234, no stall.
//  - SB addr=0x103, sd=0x000000AB, ack after 3 cycles -> we=1000, wdata=0xABABABAB, addr=0x100;
//    stall 4 cycles.
//  - LB addr=0x101, rdata=0x00008000 -> wdata_o=0xFFFFFF80; LBU -> 0x00000080; LH addr=0x102 -> 0x00000000.
//  - No ack, TIMEOUT_CYC=4 -> req high 4 cycles, then bus_err_o pulse, wreg_o=0, stall released.
//  - rst asserted in BUSY -> ram_req_o, stallreq_o, wb_valid_o all 0 next cycle; following LW works.
//  - MEM_ALIGN_CHECK_EN, LW addr=0x102 -> no ram_req_o, align_err_o=1, wreg_o=0 next cycle.

Source files
------------

// File: rtl/mem_stage_hs.sv
// Purpose: MIPS MEM stage between EX/MEM and MEM/WB; drives a req/ack RAM port, builds byte
//          enables and lane-replicated store data, and aligns and extends load data.
// Latency: non-memory ops retire 1 cycle after issue. Memory ops spend 1 IDLE cycle, then
//          request-to-ack cycles, then retire on the following edge. A hung access aborts after
//          TIMEOUT_CYC request cycles.
// Backpressure: stallreq_o freezes upstream while a memory op is in flight. It is combinational
//          on valid_i/op_i in IDLE and on ram_ack_i in BUSY. There is no downstream backpressure.
//
// Ports:
//   clk, rst           clock (rising edge); synchronous active-high reset
//   valid_i, op_i      instruction present and its memory opcode
//   addr_i             byte address
//   store_data_i       store source (rt)
//   wd_i, wreg_i       destination register and write enable
//   wdata_i            ALU result, used for non-loads
//   pc_i               instruction PC
//   wb_*, pc_o         registered MEM/WB outputs
//   ram_*              RAM handshake: request, byte enables, word address, write data,
//                      ack and read data
//   stallreq_o         freeze request to the upstream stages
//   bus_err_o          1-cycle pulse when an access is aborted by the timeout
//   align_err_o        present only with MEM_ALIGN_CHECK_EN; 1-cycle pulse on a misaligned access
//
// Build option MEM_ALIGN_CHECK_EN: when defined, misaligned halfword and word accesses are
// rejected without touching the RAM. When undefined, halfwords ignore addr[0] and words
// ignore addr[1:0].
module mem_stage_hs #(
    parameter int ADDR_W      = 32,
    parameter int REG_AW      = 5,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [3:0]        op_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       store_data_i,
    input  logic [REG_AW-1:0] wd_i,
    input  logic              wreg_i,
    input  logic [31:0]       wdata_i,
    input  logic [ADDR_W-1:0] pc_i,
    output logic              wb_valid_o,
    output logic [REG_AW-1:0] wd_o,
    output logic              wreg_o,
    output logic [31:0]       wdata_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic              ram_req_o,
    output logic [3:0]        ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [31:0]       ram_wdata_o,
    input  logic              ram_ack_i,
    input  logic [31:0]       ram_rdata_i,
    output logic              stallreq_o,
`ifdef MEM_ALIGN_CHECK_EN
    output logic              align_err_o,
`endif
    output logic              bus_err_o
);

    localparam logic [3:0] OP_LB  = 4'b0001;
    localparam logic [3:0] OP_LBU = 4'b0010;
    localparam logic [3:0] OP_LH  = 4'b0011;
    localparam logic [3:0] OP_LHU = 4'b0100;
    localparam logic [3:0] OP_LW  = 4'b0101;
    localparam logic [3:0] OP_SB  = 4'b1001;
    localparam logic [3:0] OP_SH  = 4'b1010;
    localparam logic [3:0] OP_SW  = 4'b1011;

    localparam int CNT_W = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [3:0]        lat_op;
    logic [1:0]        lat_addr_lo;
    logic [REG_AW-1:0] lat_wd;
    logic              lat_wreg;
    logic [31:0]       lat_wdata;
    logic [ADDR_W-1:0] lat_pc;

    logic              is_mem;
    logic              misaligned;
    logic              start_req;
    logic              timeout_hit;
    logic [3:0]        we_c;
    logic [31:0]       st_wdata_c;
    logic [31:0]       rd_shift;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic [31:0]       ld_result;

    // Opcode decode. Opcodes outside the table are treated as non-memory pass-through.
    always_comb begin
        is_mem     = 1'b0;
        misaligned = 1'b0;
        case (op_i)
            OP_LB, OP_LBU, OP_SB:   is_mem = 1'b1;
            OP_LH, OP_LHU, OP_SH: begin
                is_mem     = 1'b1;
                misaligned = addr_i[0];
            end
            OP_LW, OP_SW: begin
                is_mem     = 1'b1;
                misaligned = (addr_i[1:0] != 2'b00);
            end
            default: ;
        endcase
    end

`ifdef MEM_ALIGN_CHECK_EN
    assign start_req = valid_i && is_mem && !misaligned;
`else
    // Without the check, low address bits below the access size are simply ignored.
    logic unused_misaligned;
    assign unused_misaligned = misaligned;
    assign start_req = valid_i && is_mem;
`endif

    // Byte enables and lane-replicated store data, computed from the live inputs and
    // captured when the request is launched.
    always_comb begin
        we_c       = 4'b0000;
        st_wdata_c = 32'h0;
        case (op_i)
            OP_SB: begin
                we_c       = 4'b0001 << addr_i[1:0];
                st_wdata_c = {4{store_data_i[7:0]}};
            end
            OP_SH: begin
                we_c       = addr_i[1] ? 4'b1100 : 4'b0011;
                st_wdata_c = {2{store_data_i[15:0]}};
            end
            OP_SW: begin
                we_c       = 4'b1111;
                st_wdata_c = store_data_i;
            end
            default: ;
        endcase
    end

    // Load alignment uses the latched op/address. The read word is only valid in the ack cycle.
    always_comb begin
        rd_shift  = ram_rdata_i >> {lat_addr_lo, 3'b000};
        rd_byte   = rd_shift[7:0];
        rd_half   = lat_addr_lo[1] ? ram_rdata_i[31:16] : ram_rdata_i[15:0];
        ld_result = lat_wdata;
        case (lat_op)
            OP_LB:   ld_result = {{24{rd_byte[7]}}, rd_byte};
            OP_LBU:  ld_result = {24'h0, rd_byte};
            OP_LH:   ld_result = {{16{rd_half[15]}}, rd_half};
            OP_LHU:  ld_result = {16'h0, rd_half};
            OP_LW:   ld_result = ram_rdata_i;
            default: ld_result = lat_wdata;
        endcase
    end

    // An ack in the final allowed cycle wins over the timeout.
    assign timeout_hit = (state == BUSY) && !ram_ack_i && (cnt == CNT_LAST);

    // The stall is released in the ack cycle and in the abort cycle, so upstream advances on the
    // same edge that retires the memory op.
    assign stallreq_o = !rst && (((state == IDLE) && start_req) ||
                                 ((state == BUSY) && !ram_ack_i && !timeout_hit));

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            lat_op      <= 4'b0000;
            lat_addr_lo <= 2'b00;
            lat_wd      <= '0;
            lat_wreg    <= 1'b0;
            lat_wdata   <= 32'h0;
            lat_pc      <= '0;
            wb_valid_o  <= 1'b0;
            wd_o        <= '0;
            wreg_o      <= 1'b0;
            wdata_o     <= 32'h0;
            pc_o        <= '0;
            ram_req_o   <= 1'b0;
            ram_we_o    <= 4'b0000;
            ram_addr_o  <= '0;
            ram_wdata_o <= 32'h0;
            bus_err_o   <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            align_err_o <= 1'b0;
`endif
        end else begin
            bus_err_o <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            align_err_o <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (start_req) begin
                        state       <= BUSY;
                        ram_req_o   <= 1'b1;
                        ram_we_o    <= we_c;
                        ram_addr_o  <= {addr_i[ADDR_W-1:2], 2'b00};
                        ram_wdata_o <= st_wdata_c;
                        lat_op      <= op_i;
                        lat_addr_lo <= addr_i[1:0];
                        lat_wd      <= wd_i;
                        lat_wreg    <= wreg_i;
                        lat_wdata   <= wdata_i;
                        lat_pc      <= pc_i;
                        wb_valid_o  <= 1'b0;
                        wreg_o      <= 1'b0;
                    end else if (valid_i) begin
                        wb_valid_o <= 1'b1;
                        wd_o       <= wd_i;
                        wreg_o     <= wreg_i;
                        wdata_o    <= wdata_i;
                        pc_o       <= pc_i;
`ifdef MEM_ALIGN_CHECK_EN
                        // A memory op that reaches this branch was rejected as misaligned.
                        if (is_mem) begin
                            wreg_o      <= 1'b0;
                            align_err_o <= 1'b1;
                        end
`endif
                    end else begin
                        wb_valid_o <= 1'b0;
                        wreg_o     <= 1'b0;
                    end
                end
                BUSY: begin
                    if (ram_ack_i) begin
                        state      <= IDLE;
                        ram_req_o  <= 1'b0;
                        ram_we_o   <= 4'b0000;
                        wb_valid_o <= 1'b1;
                        wd_o       <= lat_wd;
                        wreg_o     <= lat_wreg;
                        wdata_o    <= ld_result;
                        pc_o       <= lat_pc;
                    end else if (timeout_hit) begin
                        state      <= IDLE;
                        ram_req_o  <= 1'b0;
                        ram_we_o   <= 4'b0000;
                        wb_valid_o <= 1'b1;
                        wd_o       <= lat_wd;
                        wreg_o     <= 1'b0;
                        wdata_o    <= 32'h0;
                        pc_o       <= lat_pc;
                        bus_err_o  <= 1'b1;
                    end else begin
                        cnt        <= cnt + 1'b1;
                        wb_valid_o <= 1'b0;
                        wreg_o     <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
